// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, default widths and bubble field values for the pipeline stall controller
package pipe_pkg;
  localparam int RADDR_W_DEF = 3;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TRAP     = 2'd2
  } state_t;
  localparam logic NOP_STORE = 1'b0;
  localparam logic [RADDR_W_DEF-1:0] NOP_RDEST = '0;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: pipeline <-> stall controller bundle; stall_cycles exists only with PIPE_STALL_STATS_EN
interface pipe_stall_ctrl_if import pipe_pkg::*; #(parameter int RADDR_W = RADDR_W_DEF) ();
  logic [RADDR_W-1:0] id_rs1_addr;
  logic               id_rs1_used;
  logic [RADDR_W-1:0] id_rs2_addr;
  logic               id_rs2_used;
  logic               ex_valid;
  logic               ex_is_load;
  logic [RADDR_W-1:0] ex_rdest_addr;
  logic               mem_req;
  logic               mem_ack;
  logic               IFtoID_Wen;
  logic               IDtoEX_Wen;
  logic               EXtoMEM_Wen;
  logic               MEMtoWB_Wen;
  logic               idex_bubble;
  logic               mem_timeout;
`ifdef PIPE_STALL_STATS_EN
  logic [15:0]        stall_cycles;
`endif
  modport master (
    output id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
    output ex_valid, ex_is_load, ex_rdest_addr, mem_req, mem_ack,
    input  IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen, idex_bubble, mem_timeout
`ifdef PIPE_STALL_STATS_EN
    , input stall_cycles
`endif
  );
  modport slave (
    input  id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
    input  ex_valid, ex_is_load, ex_rdest_addr, mem_req, mem_ack,
    output IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen, idex_bubble, mem_timeout
`ifdef PIPE_STALL_STATS_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use compare between the ID sources and the EX load destination
module pipe_hazard_detect import pipe_pkg::*; #(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic               id_rs1_used,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic               id_rs2_used,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_rdest_addr,
  output logic               hazard
);
  // r0 is hardwired zero, so a load into it never creates a dependency
  assign hazard = ex_valid && ex_is_load && (ex_rdest_addr != '0) &&
                  ((id_rs1_used && id_rs1_addr == ex_rdest_addr) ||
                   (id_rs2_used && id_rs2_addr == ex_rdest_addr));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline enable/bubble control with memory-wait freeze and timeout trap; PIPE_STALL_STATS_EN adds stall_cycles
module pipe_stall_ctrl import pipe_pkg::*; #(
  parameter int RADDR_W     = RADDR_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input logic clk,
  input logic resetn,
  pipe_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          timeout_q, timeout_n;
  logic          hazard, freeze, at_limit;
  pipe_hazard_detect #(.RADDR_W(RADDR_W)) u_hd (
    .id_rs1_addr  (bus.id_rs1_addr),
    .id_rs1_used  (bus.id_rs1_used),
    .id_rs2_addr  (bus.id_rs2_addr),
    .id_rs2_used  (bus.id_rs2_used),
    .ex_valid     (bus.ex_valid),
    .ex_is_load   (bus.ex_is_load),
    .ex_rdest_addr(bus.ex_rdest_addr),
    .hazard       (hazard)
  );
  assign at_limit = cnt == CW'(TIMEOUT_CYC);
  always_ff @(posedge clk)
    if (!resetn) begin
      st        <= ST_RUN;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      timeout_q <= timeout_n;
    end
  // an ack in the limit cycle wins over the trap
  always_comb begin
    st_n      = ST_RUN;
    cnt_n     = '0;
    timeout_n = timeout_q;
    case (st)
      ST_RUN: if (bus.mem_req && !bus.mem_ack) begin
        st_n  = ST_MEM_WAIT;
        cnt_n = CW'(1);
      end
      ST_MEM_WAIT: if (!bus.mem_ack) begin
        st_n      = at_limit ? ST_TRAP : ST_MEM_WAIT;
        cnt_n     = at_limit ? cnt : cnt + CW'(1);
        timeout_n = timeout_q | at_limit;
      end
      ST_TRAP: begin
        st_n  = ST_TRAP;
        cnt_n = cnt;
      end
      default: ;
    endcase
  end
  // inside MEM_WAIT only the ack matters; a dropped mem_req still counts as waiting
  always_comb begin
    freeze = !resetn || (st == ST_RUN      ? (bus.mem_req && !bus.mem_ack) :
                         st == ST_MEM_WAIT ? !bus.mem_ack : 1'b1);
    bus.IFtoID_Wen  = !freeze && !hazard;
    bus.IDtoEX_Wen  = !freeze;
    bus.EXtoMEM_Wen = !freeze;
    bus.MEMtoWB_Wen = !freeze;
    bus.idex_bubble = !freeze && hazard;
    bus.mem_timeout = resetn && timeout_q;
  end
`ifdef PIPE_STALL_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk)
    if (!resetn) stall_q <= '0;
    else if (!bus.IFtoID_Wen && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench with directed and random stimulus against a cycle-level behavioural model
module tb_pipe_stall_ctrl;
  localparam int TMO = 15;
  typedef struct packed {
    logic [3:0]  wen;
    logic        bub;
    logic        tmo;
    logic [15:0] sc;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  pipe_stall_ctrl_if #(.RADDR_W(3)) bus ();
  pipe_stall_ctrl #(.RADDR_W(3), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;
  bit trapped = 1'b0;
  int waited = 0;
  int unsigned sc_m = 0;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  // model: a memory access stalls until ack; TMO+1 consecutive stalled cycles trap until reset
  task automatic step(input logic rn, rq, ak, ev, ld, input logic [2:0] rd, r1, r2, input logic u1, u2);
    exp_t e;
    logic hz, stall;
    @(posedge clk);
    #1;
    resetn = rn;
    bus.mem_req = rq;
    bus.mem_ack = ak;
    bus.ex_valid = ev;
    bus.ex_is_load = ld;
    bus.ex_rdest_addr = rd;
    bus.id_rs1_addr = r1;
    bus.id_rs2_addr = r2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    hz = ev && ld && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    e.sc = sc_m[15:0];
    e.tmo = 1'b0;
    e.wen = 4'b0000;
    e.bub = 1'b0;
    if (!rn) begin
      trapped = 1'b0;
      waited = 0;
    end else if (trapped) begin
      e.tmo = 1'b1;
    end else begin
      stall = waited > 0 ? !ak : (rq && !ak);
      if (stall) begin
        waited++;
        if (waited == TMO + 1) trapped = 1'b1;
      end else begin
        e.wen = hz ? 4'b0111 : 4'b1111;
        e.bub = hz;
        waited = 0;
      end
    end
    if (!rn) sc_m = 0;
    else if (!e.wen[3] && sc_m < 65535) sc_m++;
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("wen", {12'd0, bus.IFtoID_Wen, bus.IDtoEX_Wen, bus.EXtoMEM_Wen, bus.MEMtoWB_Wen}, {12'd0, m.wen});
      chk("bubble", {15'd0, bus.idex_bubble}, {15'd0, m.bub});
      chk("timeout", {15'd0, bus.mem_timeout}, {15'd0, m.tmo});
`ifdef PIPE_STALL_STATS_EN
      chk("stall_cycles", bus.stall_cycles, m.sc);
`endif
    end
  initial begin
    {bus.mem_req, bus.mem_ack, bus.ex_valid, bus.ex_is_load, bus.id_rs1_used, bus.id_rs2_used} = '0;
    {bus.ex_rdest_addr, bus.id_rs1_addr, bus.id_rs2_addr} = '0;
    repeat (2) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 3, 0, 3, 0, 1);
    step(1, 0, 0, 0, 0, 3, 0, 3, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 1, 1, 3, 0, 3, 0, 1);
    step(1, 1, 1, 1, 1, 3, 0, 3, 0, 1);
    repeat (18) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (15) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3000)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
`ifdef PIPE_STALL_STATS_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65540) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/bubble controller for the 4-register pipeline (IFtoID, IDtoEX, EXtoMEM, MEMtoWB).
- Drives the `*_Wen` enables of all four pipeline registers.
- Inserts a bubble into IDtoEX on load-use hazards.
- Freezes the whole pipe while a MEM-stage memory access awaits acknowledge.
- Traps a memory timeout.

Parameters:
- RADDR_W, 3, register address width (8-entry regfile, r0 hardwired zero).
- TIMEOUT_CYC, 15, max cycles waiting in MEM_WAIT before the timeout trap (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising clk.
- id_rs1_addr  in  RADDR_W  ID-stage source 1 address.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_addr  in  RADDR_W  ID-stage source 2 address.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rdest_addr  in  RADDR_W  EX destination address.
- mem_req  in  1  MEM stage is accessing memory; held high until acked.
- mem_ack  in  1  memory access completes this cycle.
- IFtoID_Wen  out  1  enable for the IFtoID register.
- IDtoEX_Wen  out  1  enable for the IDtoEX register.
- EXtoMEM_Wen  out  1  enable for the EXtoMEM register.
- MEMtoWB_Wen  out  1  enable for the MEMtoWB register.
- idex_bubble  out  1  IDtoEX loads a NOP (store=0, rdest=0) instead of ID contents.
- mem_timeout  out  1  sticky memory-timeout error flag.
- stall_cycles  out  16  stall counter (optional feature only).

Behaviour:
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, TRAP=2'd2; 2'd3 is illegal and goes to RUN.
- State, wait counter and mem_timeout are registered. The enables and idex_bubble are combinational from state and inputs, so a stall takes effect in the same cycle it is detected (0-cycle latency).
- Reset (resetn=0 at a clk edge): state=RUN, wait_cnt=0, mem_timeout=0.
- While resetn=0, force all four Wen=0, idex_bubble=0, mem_timeout=0. Reset asserted mid-MEM_WAIT or in TRAP returns to RUN on the next edge.
- Wait counter width: $clog2(TIMEOUT_CYC+1) bits.
- hazard = ex_valid & ex_is_load & (ex_rdest_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_rdest_addr) | (id_rs2_used & id_rs2_addr==ex_rdest_addr)).
- memstall = mem_req & ~mem_ack.
- RUN:
  - memstall: all Wen=0, idex_bubble=0. Next state MEM_WAIT, wait_cnt=1.
  - else hazard: IFtoID_Wen=0, IDtoEX_Wen=1, idex_bubble=1, EXtoMEM_Wen=1, MEMtoWB_Wen=1. One bubble only; the hazard clears naturally next cycle.
  - else: all Wen=1, idex_bubble=0.
- MEM_WAIT:
  - mem_ack=1: enables as in RUN with memstall treated as false (hazard still evaluated). Next state RUN, wait_cnt=0.
  - mem_ack=0: all Wen=0, idex_bubble=0, wait_cnt+1.
  - mem_ack=0 and wait_cnt==TIMEOUT_CYC: next state TRAP, mem_timeout<=1.
  - An ack arriving in the same cycle as wait_cnt==TIMEOUT_CYC wins: go to RUN, no trap.
- TRAP: all Wen=0, idex_bubble=0, mem_timeout=1. Held until reset.
- Priority: memory stall > load-use bubble > run.
- mem_req dropping without ack in MEM_WAIT is a protocol violation: behaves as no-ack (counter continues).

Optional Feature:
- Macro: PIPE_STALL_STATS_EN.
- Defined:
  - Port stall_cycles[15:0] exists; registered, reset 0.
  - Increments on each clk edge where resetn=1 and IFtoID_Wen=0, i.e. memory stall, load-use or TRAP cycles.
  - Saturates at 16'hFFFF; no wrap.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package pipe_pkg: RADDR_W default, state encoding constants ST_RUN/ST_MEM_WAIT/ST_TRAP, NOP field values used for bubbles.
- One natural sub-module: pipe_hazard_detect, the purely combinational load-use compare producing hazard.
- FSM, counters and enable muxing stay in pipe_stall_ctrl.

Test Plan:
- Reset: resetn=0 for 2 clks with mem_req=1 → all Wen=0, mem_timeout=0. After release with no hazard or req → all Wen=1 on the first cycle.
- Load-use: ex_valid=1, ex_is_load=1, ex_rdest=3, id_rs2_used=1, id_rs2=3 → exactly one cycle of IFtoID_Wen=0, idex_bubble=1, others 1. Same with ex_rdest=0 → no bubble.
- Memory wait: mem_req=1, mem_ack=0 for 4 cycles, then ack → Wen=0 for 4 cycles, all Wen=1 in the ack cycle. With STATS_EN, stall_cycles=4.
- Memory stall plus hazard: hazard held throughout a 2-cycle mem wait → no bubble during the wait; bubble asserted in the ack cycle.
- Timeout: mem_req=1, mem_ack never, TIMEOUT_CYC=15 → mem_timeout=1 after the 16th stalled cycle, Wen stay 0. Ack on exactly cycle 16 → RUN, no trap. Reset clears the trap.
- Saturation (STATS_EN): force stall for 65540 cycles → stall_cycles holds 16'hFFFF.
